// File: rtl/keypad_pkg.sv
// Shared key codes, scan FSM state encoding and the keypad row/col-to-code table.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld,
    StRelease
  } kp_state_e;

  // Layout: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    unique case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      4'hF: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Row synchronizer, per-frame key evaluation and the press/release debounce FSM.
// Emits a one-cycle accept strobe with the accepted key code held until the next accept.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  input  logic       slot_end,
  input  logic [1:0] col_idx,
  output logic       accept,
  output logic [3:0] code,
  output logic       busy
);

  localparam int unsigned CW = (DEBOUNCE_CNT < 2) ? 1 : $clog2(DEBOUNCE_CNT + 1);

  logic [3:0]    row_meta_q, row_sync_q;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    fcode_q, fcode_d;
  logic [2:0]    slot_hits;
  logic [3:0]    slot_code, tot, frame_kcode;
  logic          frame_done, frame_key;
  kp_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d, code_q, code_d;
  logic          accept_q, accept_d;
  logic          cnt_last;

  always_comb begin
    slot_hits = 3'd0;
    slot_code = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync_q[r]) begin
        slot_hits = slot_hits + 3'd1;
        slot_code = key_lookup(2'(r), col_idx);
      end
    end
  end

  // Crossings accumulate over the four slots; two or more is a ghost and reads as no key.
  assign tot         = {2'b00, hits_q} + {1'b0, slot_hits};
  assign frame_done  = slot_end && (col_idx == 2'd3);
  assign frame_key   = frame_done && (tot == 4'd1);
  assign frame_kcode = (slot_hits == 3'd1) ? slot_code : fcode_q;

  always_comb begin
    hits_d  = hits_q;
    fcode_d = fcode_q;
    if (slot_end) begin
      if (frame_done) begin
        hits_d  = 2'd0;
        fcode_d = 4'h0;
      end else begin
        hits_d  = (tot >= 4'd2) ? 2'd2 : tot[1:0];
        fcode_d = frame_kcode;
      end
    end
  end

  assign cnt_last = (32'(cnt_q) + 32'd1) == DEBOUNCE_CNT;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept_d = 1'b0;
    if (frame_done) begin
      unique case (state_q)
        StScan: begin
          if (frame_key) begin
            cand_d = frame_kcode;
            cnt_d  = CW'(1);
            if (DEBOUNCE_CNT == 1) begin
              state_d  = StHeld;
              accept_d = 1'b1;
            end else begin
              state_d = StDebounce;
            end
          end
        end
        StDebounce: begin
          if (frame_key && (frame_kcode == cand_q)) begin
            if (cnt_last) begin
              state_d  = StHeld;
              accept_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            state_d = StScan;
          end
        end
        StHeld: begin
          if (!frame_key) begin
            cnt_d   = CW'(1);
            state_d = (DEBOUNCE_CNT == 1) ? StScan : StRelease;
          end
        end
        StRelease: begin
          if (frame_key) begin
            state_d = StHeld;
          end else if (cnt_last) begin
            state_d = StScan;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  assign code_d = accept_d ? cand_d : code_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      hits_q     <= 2'd0;
      fcode_q    <= 4'h0;
      state_q    <= StScan;
      cnt_q      <= '0;
      cand_q     <= 4'h0;
      code_q     <= 4'h0;
      accept_q   <= 1'b0;
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
      hits_q     <= hits_d;
      fcode_q    <= fcode_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      code_q     <= code_d;
      accept_q   <= accept_d;
    end
  end

  assign accept = accept_q;
  assign code   = code_q;
  assign busy   = (state_q != StScan);

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad front end: column scan, debounce and a 4-digit BCD entry register.
// Optional idle auto-clear of the entry when KEYPAD_TIMEOUT_EN is defined.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned TIMEOUT_CYC  = 250000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] digits,
  output logic [2:0]  digit_count,
  output logic        enter,
  output logic        busy
);

  localparam int unsigned DW = $clog2(SCAN_DIV);

  logic [DW-1:0] div_q;
  logic [1:0]    col_q;
  logic          slot_end;
  logic          accept;
  logic [3:0]    code;
  logic [15:0]   digits_q, digits_d;
  logic [2:0]    count_q, count_d;

  assign slot_end = (div_q == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      col_q <= 2'd0;
    end else if (slot_end) begin
      div_q <= '0;
      col_q <= col_q + 2'd1;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  assign col_out = ~(4'b0001 << col_q);

  keypad_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .row_in  (row_in),
    .slot_end(slot_end),
    .col_idx (col_q),
    .accept  (accept),
    .code    (code),
    .busy    (busy)
  );

`ifdef KEYPAD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_q, to_d;
  logic          to_run, to_hit;

  assign to_run = !busy && (count_q != 3'd0);
  assign to_hit = to_run && (to_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    to_d = to_q;
    if (accept || to_hit) to_d = '0;
    else if (to_run)      to_d = to_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) to_q <= '0;
    else     to_q <= to_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYC;
`endif

  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    if (accept) begin
      if (code <= 4'd9) begin
        digits_d = {digits_q[11:0], code};
        count_d  = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
      end else if (code == KEY_STAR) begin
        digits_d = 16'h0000;
        count_d  = 3'd0;
      end
    end
`ifdef KEYPAD_TIMEOUT_EN
    else if (to_hit) begin
      digits_d = 16'h0000;
      count_d  = 3'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= 16'h0000;
      count_q  <= 3'd0;
    end else begin
      digits_q <= digits_d;
      count_q  <= count_d;
    end
  end

  assign key_valid   = accept;
  assign key_code    = code;
  assign enter       = accept && (code == KEY_HASH);
  assign digits      = digits_q;
  assign digit_count = count_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: keypad matrix model, entry/scan reference model and per-cycle compare.
module tb_keypad_entry;

  localparam int unsigned SCAN_DIV     = 8;
  localparam int unsigned DEBOUNCE_CNT = 2;
  localparam int unsigned TIMEOUT_CYC  = 200;
  localparam int          FRAME        = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in, col_out, key_code;
  logic        key_valid, enter, busy;
  logic [15:0] digits;
  logic [2:0]  digit_count;

  always #5 clk = ~clk;

  keypad_entry #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .digits     (digits),
    .digit_count(digit_count),
    .enter      (enter),
    .busy       (busy)
  );

  // Key at row r, col c sits at index r*4+c.
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  logic [15:0] pmask = 16'h0;

  always_comb begin
    row_in = 4'hF;
    for (int i = 0; i < 16; i++)
      if (pmask[i] && !col_out[i % 4]) row_in[i / 4] = 1'b0;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;
  int exp_lat = -1;
  int n_enter = 0;
  bit chk_en = 1'b0;
  int dq[$];
  logic [3:0] expq[$];

  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] key_bit(input logic [3:0] k);
    logic [15:0] m;
    m = 16'h0;
    for (int i = 0; i < 16; i++) if (keymap[i] == k) m = 16'h1 << i;
    return m;
  endfunction

  function automatic logic [15:0] model_digits();
    logic [15:0] md;
    md = 16'h0;
    foreach (dq[i]) md = (md << 4) | 16'(dq[i]);
    return md;
  endfunction

  function automatic logic [3:0] exp_col(input int cyc);
    int idx;
    idx = (cyc / SCAN_DIV) % 4;
    return 4'hF ^ (4'b0001 << idx);
  endfunction

  always @(negedge clk) begin
    logic [3:0] c;
    if (chk_en) begin
      chk("col_out", 32'(col_out), 32'(exp_col(n)));
      chk("digits", 32'(digits), 32'(model_digits()));
      chk("digit_count", 32'(digit_count), dq.size());
      if (key_valid) begin
        if (enter) n_enter++;
        if (expq.size() == 0) begin
          chk("unexpected key_valid", 32'(key_code), 32'hFFFF);
        end else begin
          c = expq.pop_front();
          chk("key_code", 32'(key_code), 32'(c));
          chk("enter with key", 32'(enter), 32'(c == 4'hF));
          if (exp_lat >= 0) chk("latency", n, exp_lat);
          exp_lat = -1;
          if (c <= 4'd9) begin
            dq.push_back(int'(c));
            if (dq.size() > 4) void'(dq.pop_front());
          end else if (c == 4'hE) begin
            dq.delete();
          end
        end
      end else begin
        chk("enter idle", 32'(enter), 32'd0);
      end
    end
  end

  task automatic align();
    do @(negedge clk); while (n % FRAME != 0);
  endtask

  // Press a set of keys at a frame boundary, hold, release, then verify it settled.
  task automatic press(input logic [15:0] mask, input int hold, input int gap,
                       input bit exp_key, input logic [3:0] k);
    align();
    if (exp_key) begin
      expq.push_back(k);
      exp_lat = n + DEBOUNCE_CNT * FRAME;
    end
    pmask = mask;
    repeat (hold * FRAME) @(negedge clk);
    chk("busy while held", 32'(busy), 32'(exp_key));
    pmask = 16'h0;
    repeat (gap * FRAME) @(negedge clk);
    chk("accept delivered", expq.size(), 0);
    chk("busy after release", 32'(busy), 32'd0);
    exp_lat = -1;
  endtask

  task automatic press_key(input logic [3:0] k);
    press(key_bit(k), DEBOUNCE_CNT + 2, DEBOUNCE_CNT + 2, 1'b1, k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset col_out", 32'(col_out), 32'hE);
    chk("reset key_valid", 32'(key_valid), 32'd0);
    chk("reset key_code", 32'(key_code), 32'd0);
    chk("reset digits", 32'(digits), 32'd0);
    chk("reset digit_count", 32'(digit_count), 32'd0);
    chk("reset enter", 32'(enter), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    press(key_bit(4'h5), 10, DEBOUNCE_CNT + 2, 1'b1, 4'h5);
    chk("lit code 5", 32'(key_code), 32'h5);
    chk("lit digits 5", 32'(digits), 32'h0005);
    chk("lit count 1", 32'(digit_count), 32'd1);

    press_key(4'h1); press_key(4'h2); press_key(4'h3); press_key(4'h4); press_key(4'h9);
    chk("lit digits 2349", 32'(digits), 32'h2349);
    chk("lit count 4", 32'(digit_count), 32'd4);
    press_key(4'hE);
    chk("lit digits cleared", 32'(digits), 32'h0);
    chk("lit count cleared", 32'(digit_count), 32'd0);

    press_key(4'h7);
    press_key(4'hF);
    chk("lit code hash", 32'(key_code), 32'hF);
    chk("lit digits 0007", 32'(digits), 32'h0007);
    chk("lit enter pulses", n_enter, 1);

    // Bouncing contact for one frame, then a solid hold of '8'.
    align();
    expq.push_back(4'h8);
    for (int i = 0; i < FRAME; i++) begin
      if (i % 3 == 0) pmask = pmask ^ key_bit(4'h8);
      @(negedge clk);
    end
    pmask = key_bit(4'h8);
    repeat (8 * FRAME) @(negedge clk);
    pmask = 16'h0;
    repeat ((DEBOUNCE_CNT + 2) * FRAME) @(negedge clk);
    chk("bounce accepted once", expq.size(), 0);
    chk("lit code 8", 32'(key_code), 32'h8);

    press(key_bit(4'h1) | key_bit(4'h2), 6, DEBOUNCE_CNT + 2, 1'b0, 4'h0);
    chk("lit ghost digits", 32'(digits), 32'h0078);
    chk("lit ghost code", 32'(key_code), 32'h8);

    // Reset while a press is being debounced.
    align();
    pmask = key_bit(4'h6);
    repeat (FRAME + 4) @(negedge clk);
    chk("busy in debounce", 32'(busy), 32'd1);
    rst = 1'b1;
    pmask = 16'h0;
    chk_en = 1'b0;
    @(negedge clk);
    chk("rst col_out", 32'(col_out), 32'hE);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst key_valid", 32'(key_valid), 32'd0);
    chk("rst digits", 32'(digits), 32'd0);
    rst = 1'b0;
    dq.delete();
    chk_en = 1'b1;
    repeat (4 * FRAME) @(negedge clk);
    chk("rst key_code", 32'(key_code), 32'd0);

    for (int p = 0; p < 24; p++) begin
      k = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0)
        press(key_bit(k) | key_bit(k + 4'd1), $urandom_range(DEBOUNCE_CNT, DEBOUNCE_CNT + 4),
              $urandom_range(DEBOUNCE_CNT + 1, DEBOUNCE_CNT + 3), 1'b0, 4'h0);
      else
        press(key_bit(k), $urandom_range(DEBOUNCE_CNT, DEBOUNCE_CNT + 4),
              $urandom_range(DEBOUNCE_CNT + 1, DEBOUNCE_CNT + 3), 1'b1, k);
    end

`ifdef KEYPAD_TIMEOUT_EN
    press_key(4'hE);
    press_key(4'h3);
    chk("lit timeout pre", 32'(digits), 32'h0003);
    chk_en = 1'b0;
    repeat (2 * TIMEOUT_CYC) @(negedge clk);
    chk("timeout digits", 32'(digits), 32'd0);
    chk("timeout count", 32'(digit_count), 32'd0);
    chk("timeout code held", 32'(key_code), 32'h3);
    dq.delete();
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
